// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write-back path: PPP mode codes,
// default widths and the write-request record.
package rf_pkg;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int PPP_WIDTH      = 3;

    typedef enum logic [0:PPP_WIDTH-1] {
        MODE_A = 3'b000,
        MODE_U = 3'b001,
        MODE_D = 3'b010,
        MODE_E = 3'b011,
        MODE_O = 3'b100
    } ppp_mode_e;

    typedef struct packed {
        logic [0:DEF_ADDR_WIDTH-1] addr;
        logic [0:DEF_DATA_WIDTH-1] data;
        logic [0:PPP_WIDTH-1]      ppp;
    } wr_req_t;

    // Codes above MODE_O are reserved and never reach the register file.
    function automatic logic ppp_is_valid(input logic [0:PPP_WIDTH-1] ppp);
        return (ppp <= MODE_O);
    endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO with a registered occupancy count; the head entry is
// always visible so the arbiter can inspect it before popping.
module rf_wb_fifo #(
    parameter int WIDTH = 72,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [0:WIDTH-1] wr_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [0:WIDTH-1] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [0:WIDTH-1] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // Full FIFOs refuse pushes even if the head pops on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so plain increments wrap the pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register file write port between the ALU (port 0) and NoC load
// returns (port 1). Define RF_WB_RR_EN for round-robin, else port 0 has priority.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb0_valid,
    output logic                  wb0_ready,
    input  logic [0:ADDR_WIDTH-1] wb0_addr,
    input  logic [0:DATA_WIDTH-1] wb0_data,
    input  logic [0:PPP_WIDTH-1]  wb0_ppp,
    input  logic                  wb1_valid,
    output logic                  wb1_ready,
    input  logic [0:ADDR_WIDTH-1] wb1_addr,
    input  logic [0:DATA_WIDTH-1] wb1_data,
    input  logic [0:PPP_WIDTH-1]  wb1_ppp,
    output logic                  rf_wen,
    output logic [0:ADDR_WIDTH-1] rf_wr_addr,
    output logic [0:DATA_WIDTH-1] rf_data,
    output logic [0:PPP_WIDTH-1]  rf_ppp_sel,
    output logic                  rf_busy
);

    localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH + PPP_WIDTH;

`ifdef RF_WB_RR_EN
    localparam bit ROUND_ROBIN = 1'b1;
`else
    localparam bit ROUND_ROBIN = 1'b0;
`endif

    logic                  full0, empty0, full1, empty1;
    logic [0:ENTRY_W-1]    head0, head1;
    logic [0:ADDR_WIDTH-1] h0_addr, h1_addr;
    logic [0:DATA_WIDTH-1] h0_data, h1_data;
    logic [0:PPP_WIDTH-1]  h0_ppp, h1_ppp;
    logic                  disc0, disc1;
    logic                  cand0, cand1;
    logic                  grant0, grant1;
    logic                  pop0, pop1;
    logic                  last_grant;

    rf_wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo0 (
        .clk     (clk),
        .reset   (reset),
        .push    (wb0_valid),
        .wr_data ({wb0_addr, wb0_data, wb0_ppp}),
        .pop     (pop0),
        .full    (full0),
        .empty   (empty0),
        .head    (head0)
    );

    rf_wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo1 (
        .clk     (clk),
        .reset   (reset),
        .push    (wb1_valid),
        .wr_data ({wb1_addr, wb1_data, wb1_ppp}),
        .pop     (pop1),
        .full    (full1),
        .empty   (empty1),
        .head    (head1)
    );

    assign h0_addr = head0[0 +: ADDR_WIDTH];
    assign h0_data = head0[ADDR_WIDTH +: DATA_WIDTH];
    assign h0_ppp  = head0[ADDR_WIDTH + DATA_WIDTH +: PPP_WIDTH];
    assign h1_addr = head1[0 +: ADDR_WIDTH];
    assign h1_data = head1[ADDR_WIDTH +: DATA_WIDTH];
    assign h1_ppp  = head1[ADDR_WIDTH + DATA_WIDTH +: PPP_WIDTH];

    assign wb0_ready = !full0;
    assign wb1_ready = !full1;
    assign rf_busy   = !empty0 || !empty1;

    // Heads that target r0 or carry a reserved PPP code are dropped silently.
    always_comb begin
        disc0  = !empty0 && ((h0_addr == '0) || !ppp_is_valid(h0_ppp));
        disc1  = !empty1 && ((h1_addr == '0) || !ppp_is_valid(h1_ppp));
        cand0  = !empty0 && !disc0;
        cand1  = !empty1 && !disc1;
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (cand0 && cand1) begin
            if (ROUND_ROBIN && (last_grant == 1'b0)) begin
                grant1 = 1'b1;
            end else begin
                grant0 = 1'b1;
            end
        end else begin
            grant0 = cand0;
            grant1 = cand1;
        end
    end

    assign pop0 = (grant0 || disc0) && !reset;
    assign pop1 = (grant1 || disc1) && !reset;

    always_comb begin
        rf_wen     = 1'b0;
        rf_wr_addr = '0;
        rf_data    = '0;
        rf_ppp_sel = '0;
        if (!reset) begin
            if (grant0) begin
                rf_wen     = 1'b1;
                rf_wr_addr = h0_addr;
                rf_data    = h0_data;
                rf_ppp_sel = h0_ppp;
            end else if (grant1) begin
                rf_wen     = 1'b1;
                rf_wr_addr = h1_addr;
                rf_data    = h1_data;
                rf_ppp_sel = h1_ppp;
            end
        end
    end

    // Starting at 1 lets port 0 win the first contended cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (grant0) begin
            last_grant <= 1'b0;
        end else if (grant1) begin
            last_grant <= 1'b1;
        end
    end

endmodule
